// File: rtl/adder_subtractor4_bist.sv
// Built-in self-test engine for the 4-bit adder/subtractor: sweeps all 1024
// {a,b,ci,sub} vectors, checks {co,g} against an internal reference, and logs errors.
module adder_subtractor4_bist #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_CNT_W     = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [3:0]           a,
  output logic [3:0]           b,
  output logic                 ci,
  output logic                 sub,
  input  logic [3:0]           g,
  input  logic                 co,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 first_err_valid,
  output logic [9:0]           first_err_vec
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [3:0]           SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX     = '1;
  localparam logic [ERR_CNT_W-1:0] ERR_ONE     = ERR_CNT_W'(1);

  state_t               state_reg, state_next;
  logic [9:0]           idx_reg, idx_next;
  logic [3:0]           settle_reg, settle_next;
  logic [ERR_CNT_W-1:0] err_reg, err_next;
  logic                 first_valid_reg, first_valid_next;
  logic [9:0]           first_vec_reg, first_vec_next;

  logic [3:0] b_x;
  logic [4:0] expected;
  logic       mismatch;

  // Subtraction is a + ~b + ~ci, so both b and ci are conditionally inverted by sub.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_binv
      assign b_x[gi] = idx_reg[2+gi] ^ idx_reg[0];
    end
  endgenerate

  assign expected = {1'b0, idx_reg[9:6]} + {1'b0, b_x} + {4'b0000, idx_reg[1] ^ idx_reg[0]};
  assign mismatch = ({co, g} != expected);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      settle_reg      <= '0;
      err_reg         <= '0;
      first_valid_reg <= 1'b0;
      first_vec_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      settle_reg      <= settle_next;
      err_reg         <= err_next;
      first_valid_reg <= first_valid_next;
      first_vec_reg   <= first_vec_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    settle_next      = settle_reg;
    err_next         = err_reg;
    first_valid_next = first_valid_reg;
    first_vec_next   = first_vec_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          idx_next         = '0;
          err_next         = '0;
          first_valid_next = 1'b0;
          first_vec_next   = '0;
          settle_next      = SETTLE_LOAD;
          state_next       = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_reg == 4'd0) state_next = CHECK;
        else                    settle_next = settle_reg - 4'd1;
      end
      CHECK: begin
        if (mismatch) begin
          if (err_reg != ERR_MAX) err_next = err_reg + ERR_ONE;
          if (!first_valid_reg) begin
            first_valid_next = 1'b1;
            first_vec_next   = idx_reg;
          end
        end
        if (idx_reg == 10'h3FF) begin
          state_next = DONE;
        end else begin
          idx_next    = idx_reg + 10'd1;
          settle_next = SETTLE_LOAD;
          state_next  = SETTLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // All outputs come from registers only; g/co reach nothing but next-state logic.
  assign a               = idx_reg[9:6];
  assign b               = idx_reg[5:2];
  assign ci              = idx_reg[1];
  assign sub             = idx_reg[0];
  assign busy            = (state_reg == SETTLE) || (state_reg == CHECK);
  assign done            = (state_reg == DONE);
  assign pass            = done && (err_reg == '0);
  assign err_count       = err_reg;
  assign first_err_valid = first_valid_reg;
  assign first_err_vec   = first_vec_reg;

endmodule

// File: tb/tb_adder_subtractor4_bist.sv
// Bench for adder_subtractor4_bist: a behavioural unit with injectable faults,
// randomized fault patterns and an arithmetic reference model of the sweep results.
module tb_adder_subtractor4_bist;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;

  logic [3:0]  a, b, g;
  logic        ci, sub, co, busy, done, pass, first_err_valid;
  logic [10:0] err_count;
  logic [9:0]  first_err_vec;

  logic [3:0]  s_a, s_b, s_g;
  logic        s_ci, s_sub, s_co, s_busy, s_done, s_pass, s_first_err_valid;
  logic [3:0]  s_err_count;
  logic [9:0]  s_first_err_vec;

  // 0 none, 1 stuck-at output bit, 2 xor on v%mod==rem, 3 xor on single vector
  int fault_kind = 0, fault_bit = 0, fault_val = 0, fault_mod = 2, fault_rem = 0, fault_mask = 0;

  int assert_count = 0;
  int fail_count   = 0;
  int seq_errors   = 0;

  always #5 clk = ~clk;

  adder_subtractor4_bist dut (
    .clk(clk), .reset(reset), .start(start),
    .a(a), .b(b), .ci(ci), .sub(sub), .g(g), .co(co),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_valid(first_err_valid), .first_err_vec(first_err_vec)
  );

  adder_subtractor4_bist #(.SETTLE_CYCLES(1), .ERR_CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .start(start),
    .a(s_a), .b(s_b), .ci(s_ci), .sub(s_sub), .g(s_g), .co(s_co),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err_count),
    .first_err_valid(s_first_err_valid), .first_err_vec(s_first_err_vec)
  );

  function automatic int good_result(input int v);
    int av, bv, cv, sv;
    av = (v >> 6) & 15;
    bv = (v >> 2) & 15;
    cv = (v >> 1) & 1;
    sv = v & 1;
    // Subtract result is biased by 16 so bit 4 reads as "no borrow".
    return sv ? (av - bv - cv + 16) : (av + bv + cv);
  endfunction

  function automatic logic [4:0] unit_fn(input int v, input int kind, input int fbit,
                                         input int fval, input int fmod, input int frem,
                                         input int fmask);
    logic [4:0] r;
    r = 5'(good_result(v));
    case (kind)
      1: r[fbit] = fval[0];
      2: if ((v % fmod) == frem) r = r ^ 5'(fmask);
      3: if (v == frem) r = r ^ 5'(fmask);
      default: ;
    endcase
    return r;
  endfunction

  always_comb {co, g} = unit_fn(int'({a, b, ci, sub}), fault_kind, fault_bit, fault_val,
                                fault_mod, fault_rem, fault_mask);
  always_comb {s_co, s_g} = unit_fn(int'({s_a, s_b, s_ci, s_sub}), fault_kind, fault_bit,
                                    fault_val, fault_mod, fault_rem, fault_mask);

  // Vector order monitor: every sweep starts at 0 and steps by exactly one.
  int  last_vec = 0;
  bit  prev_busy = 1'b0;
  always @(negedge clk) begin
    int vec;
    vec = int'({a, b, ci, sub});
    if (busy && !prev_busy) begin
      if (vec != 0) seq_errors++;
      last_vec = vec;
    end else if (busy && vec != last_vec) begin
      if (vec != last_vec + 1) seq_errors++;
      last_vec = vec;
    end
    prev_busy = busy;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model(output int cnt, output int valid, output int first);
    cnt = 0; valid = 0; first = 0;
    for (int v = 0; v < 1024; v++) begin
      if (int'(unit_fn(v, fault_kind, fault_bit, fault_val, fault_mod, fault_rem, fault_mask))
          != good_result(v)) begin
        if (valid == 0) begin valid = 1; first = v; end
        cnt++;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_vec"},   {a, b, ci, sub}, 0);
    check({tag, "_flags"}, {busy, done, pass, first_err_valid}, 0);
    check({tag, "_err"},   err_count, 0);
    check({tag, "_first"}, first_err_vec, 0);
    check({tag, "_sat"},   {s_a, s_b, s_ci, s_sub, s_busy, s_done, s_pass, s_err_count,
                            s_first_err_valid, s_first_err_vec}, 0);
  endtask

  task automatic run_sweep(input string name, input int restart_at);
    int cnt, guard, exp_cnt, exp_valid, exp_first, seq0;
    model(exp_cnt, exp_valid, exp_first);
    seq0 = seq_errors;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check({name, "_ack"}, {done, busy, s_done, s_busy}, 4'b0101);
    cnt = 0; guard = 0;
    while (!done && guard < 6000) begin
      if (busy) cnt++;
      start = (restart_at != 0 && cnt == restart_at);
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b0;
    check({name, "_done"}, {done, busy, s_done, s_busy}, 4'b1010);
    check({name, "_busy_cycles"}, cnt, 2048);
    check({name, "_seq"}, seq_errors - seq0, 0);
    check({name, "_last_vec"}, {a, b, ci, sub}, 10'h3FF);
    check({name, "_err"}, err_count, exp_cnt);
    check({name, "_pass"}, pass, exp_cnt == 0);
    check({name, "_fvalid"}, first_err_valid, exp_valid);
    check({name, "_fvec"}, first_err_vec, exp_first);
    check({name, "_sat_err"}, s_err_count, (exp_cnt > 15) ? 15 : exp_cnt);
    check({name, "_sat_pass"}, s_pass, exp_cnt == 0);
    check({name, "_sat_fvec"}, {s_first_err_valid, s_first_err_vec}, {exp_valid[0], 10'(exp_first)});
    $display("sweep %s: kind=%0d err=%0d first_valid=%0d first_vec=%0d busy_cycles=%0d",
             name, fault_kind, err_count, first_err_valid, first_err_vec, cnt);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_zero("idle");

    // Clean unit, with a spot check on vector 0x0D7 along the way.
    fault_kind = 0;
    run_sweep("clean", 0);
    check("spot_0d7", unit_fn(10'h0D7, 0, 0, 0, 2, 0, 0), 5'b01101);

    // g[0] stuck at 0: half the vectors fail, first at idx 2.
    fault_kind = 1; fault_bit = 0; fault_val = 0;
    run_sweep("g0_sa0", 0);
    check("g0_sa0_err_const", err_count, 512);
    check("g0_sa0_fvec_const", first_err_vec, 2);
    check("g0_sa0_sat_const", s_err_count, 15);
    // Restart from DONE with identical results, plus an ignored mid-sweep start.
    run_sweep("g0_sa0_rerun", 50);

    // Reset 100 cycles into a sweep.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (99) @(posedge clk);
    #2 reset = 1'b1;
    #1 check_zero("midreset");
    @(posedge clk); #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    #1 check_zero("post_reset_idle");
    fault_kind = 0;
    run_sweep("after_reset", 0);

    for (int i = 0; i < 4; i++) begin
      fault_kind = $urandom_range(1, 3);
      fault_bit  = $urandom_range(0, 4);
      fault_val  = $urandom_range(0, 1);
      fault_mod  = $urandom_range(2, 300);
      fault_rem  = $urandom_range(0, fault_mod - 1);
      if (fault_kind == 3) fault_rem = $urandom_range(0, 1023);
      fault_mask = $urandom_range(1, 31);
      run_sweep($sformatf("rand%0d", i), (i == 1) ? int'($urandom_range(1, 2000)) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
